m_gen_bcd_cnt: RTL and testbench
================================

// Module: m_gen_bcd_cnt
// PURPOSE
//  Parametrised BCD modulo counter for the stopwatch time chain (seconds, minutes, hours, hundredths).
//  Advances on a single-cycle tick strobe in the system clock domain and holds NDIGITS packed BCD digits.
//  Emits a one-cycle carry pulse on wrap, which drives the next stage's tick. Supports sync clear and load.
//  Cascading instances (MODULUS 100 -> 60 -> 60 -> 24) forms the full stopwatch timebase.
// PARAMETERS
//  NDIGITS      2   number of BCD digits (1..4); count width = 4*NDIGITS
//  MODULUS      60  count range 0..MODULUS-1; legal 2..10**NDIGITS
//  RESET_VALUE  0   binary value loaded on reset; must be < MODULUS
// PORTS
//  clk        in   1          system clock; all state on posedge clk
//  rst_n      in   1          asynchronous active-low reset
//  tick       in   1          count strobe, one clk wide; ignored while low
//  clr        in   1          synchronous clear to 0
//  load       in   1          synchronous load of load_val
//  load_val   in   4*NDIGITS  packed BCD value to load, digit 0 in [3:0]
//  count      out  4*NDIGITS  packed BCD count, digit 0 in [3:0]
//  carry      out  1          one-cycle pulse on wrap (up: MODULUS-1 -> 0)
//  load_err   out  1          one-cycle pulse when a load is rejected
// BEHAVIOUR
//  - Reset (rst_n low, async): count = BCD(RESET_VALUE), carry = 0, load_err = 0.
//  - Per-cycle priority: clr > load > tick. Lower-priority requests in the same cycle are dropped.
//  - clr: count <= 0 next cycle; carry = 0.
//  - load: accepted if every digit <= 9 and value < MODULUS. Then count <= load_val; carry = 0.
//    Otherwise count holds and load_err = 1 for one cycle.
//  - tick (up): if count == MODULUS-1, count <= 0 and carry = 1 in the same cycle the new count appears.
//    Otherwise, BCD increment: a digit at 9 becomes 0 and increments the next digit.
//  - Latency: count and carry are registered; both update 1 clk after the qualifying edge.
//  - carry and load_err are 0 in every cycle not named above. There is no combinational path from tick to carry.
//  - Arithmetic is purely BCD; no binary intermediate is kept. The modulus compare is against the BCD constant.
//  - If rst_n is asserted mid-operation, state returns to RESET_VALUE immediately and any pending carry is lost.
//  - Elaboration error if MODULUS > 10**NDIGITS, MODULUS < 2, or RESET_VALUE >= MODULUS.
// CONFIGURATION
//  Macro GEN_BCD_CNT_DOWN_EN:
//  - Defined: adds input port `down` (1 bit). When down = 1, tick decrements.
//    0 wraps to MODULUS-1, and carry pulses as a borrow on that wrap. A digit at 0 becomes 9 and borrows.
//  - Not defined: no `down` port; the counter is up-only, as described above.
// STRUCTURE
//  - Package m_bcd_pkg holds:
//    - typedef logic [3:0] bcd_digit_t
//    - constant BCD_MAX = 4'd9
//    - function to_bcd(int v, int n), used for MODULUS-1 and RESET_VALUE constants
//    - function is_bcd(digit)
//  - Sub-module m_bcd_digit: one decade cell with inc/dec enable in, digit out, and a terminal flag (==9 / ==0).
//    Instantiated NDIGITS times via generate; the top level applies the modulus wrap and the load checks.
// TESTING
//  1. Reset with NDIGITS=2, MODULUS=60, RESET_VALUE=59. Release rst_n, then apply one tick
//     -> count 0x59 after reset, then 0x00 with carry=1 for exactly 1 cycle.
//  2. Apply 60 ticks from 0 with random 0..3 idle cycles between them
//     -> count walks 0x00..0x59, returns to 0x00, and exactly one carry pulse occurs.
//  3. load_val=0x37 -> count 0x37. Then load_val=0x60 -> count stays 0x37 and load_err pulses.
//     Then load_val=0x4A -> load_err pulses.
//  4. Assert clr, load and tick in the same cycle at count 0x59 -> count 0x00 and carry=0.
//  5. NDIGITS=3, MODULUS=100: 100 ticks -> count reaches 0x099, then wraps to 0x000 with carry;
//     the upper digit stays 0 throughout.
//  6. With GEN_BCD_CNT_DOWN_EN defined, down=1, count 0x00, apply a tick
//     -> count 0x59 and carry=1; a further tick -> 0x58. Assert rst_n mid-count -> immediate RESET_VALUE.

Source files
------------

// File: rtl/m_bcd_pkg.sv
// Shared BCD types and constant helpers for the stopwatch counter chain.
// Used by m_bcd_digit and m_gen_bcd_cnt (macro GEN_BCD_CNT_DOWN_EN is handled in the top).
package m_bcd_pkg;

    typedef logic [3:0] bcd_digit_t;

    localparam bcd_digit_t BCD_MAX = 4'd9;

    // Elaboration-time binary to packed BCD; digits above n are left zero.
    function automatic logic [15:0] to_bcd(input int v, input int n);
        logic [15:0] r;
        int          t;
        r = '0;
        t = v;
        for (int i = 0; i < 4; i++) begin
            if (i < n) begin
                r[i*4 +: 4] = 4'(t % 10);
                t           = t / 10;
            end
        end
        return r;
    endfunction

    function automatic logic is_bcd(input bcd_digit_t d);
        return d <= BCD_MAX;
    endfunction

endpackage

// File: rtl/m_bcd_digit.sv
// One BCD decade: synchronous set, +1/-1 step with 9<->0 rollover, and a terminal flag
// (==9 counting up, ==0 counting down) that enables the next decade.
module m_bcd_digit
    import m_bcd_pkg::*;
#(
    parameter bcd_digit_t RESET_DIGIT = 4'd0
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       i_set,
    input  bcd_digit_t i_set_val,
    input  logic       i_en,
    input  logic       i_down,
    output bcd_digit_t o_digit,
    output logic       o_term
);

    bcd_digit_t r_digit;
    bcd_digit_t w_digit_nxt;

    always_comb begin
        w_digit_nxt = r_digit;
        if (i_set) begin
            w_digit_nxt = i_set_val;
        end else if (i_en) begin
            if (i_down) begin
                w_digit_nxt = (r_digit == 4'd0) ? BCD_MAX : r_digit - 4'd1;
            end else begin
                w_digit_nxt = (r_digit == BCD_MAX) ? 4'd0 : r_digit + 4'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_digit <= RESET_DIGIT;
        end else begin
            r_digit <= w_digit_nxt;
        end
    end

    assign o_digit = r_digit;
    assign o_term  = i_down ? (r_digit == 4'd0) : (r_digit == BCD_MAX);

endmodule

// File: rtl/m_gen_bcd_cnt.sv
// Parametrised BCD modulo counter with clear/load/tick and a registered wrap carry.
// Define GEN_BCD_CNT_DOWN_EN to add the `down` port (tick decrements, carry acts as borrow).
module m_gen_bcd_cnt
    import m_bcd_pkg::*;
#(
    parameter int unsigned NDIGITS     = 2,
    parameter int unsigned MODULUS     = 60,
    parameter int unsigned RESET_VALUE = 0
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 tick,
    input  logic                 clr,
    input  logic                 load,
`ifdef GEN_BCD_CNT_DOWN_EN
    input  logic                 down,
`endif
    input  logic [4*NDIGITS-1:0] load_val,
    output logic [4*NDIGITS-1:0] count,
    output logic                 carry,
    output logic                 load_err
);

    localparam int unsigned W = 4 * NDIGITS;

    if (NDIGITS < 1 || NDIGITS > 4 || MODULUS < 2 || MODULUS > 10 ** NDIGITS ||
        RESET_VALUE >= MODULUS) begin : g_param_err
        $error("m_gen_bcd_cnt: illegal NDIGITS/MODULUS/RESET_VALUE combination");
    end

    localparam logic [15:0]  C_MAX_FULL = to_bcd(int'(MODULUS - 1), int'(NDIGITS));
    localparam logic [15:0]  C_RST_FULL = to_bcd(int'(RESET_VALUE), int'(NDIGITS));
    localparam logic [W-1:0] C_MAX_BCD  = C_MAX_FULL[W-1:0];
    localparam logic [W-1:0] C_RST_BCD  = C_RST_FULL[W-1:0];

    logic               w_down;
    bcd_digit_t         w_digit [NDIGITS];
    logic [NDIGITS-1:0] w_term;
    logic [NDIGITS-1:0] w_en;
    logic               w_set;
    logic [W-1:0]       w_set_val;
    logic               w_step;
    logic               w_wrap;
    logic               w_ld_ok;
    logic               w_carry_nxt;
    logic               w_err_nxt;
    logic               r_carry;
    logic               r_load_err;

`ifdef GEN_BCD_CNT_DOWN_EN
    assign w_down = down;
`else
    assign w_down = 1'b0;
`endif

    // Down-wrap point is all digits at zero, which is exactly every terminal flag set.
    assign w_wrap = w_down ? (&w_term) : (count == C_MAX_BCD);

    always_comb begin
        w_set       = 1'b0;
        w_set_val   = '0;
        w_step      = 1'b0;
        w_carry_nxt = 1'b0;
        w_err_nxt   = 1'b0;
        // With every nibble <= 9, packed BCD orders the same as the value it encodes.
        w_ld_ok     = (load_val <= C_MAX_BCD);
        for (int i = 0; i < int'(NDIGITS); i++) begin
            w_ld_ok = w_ld_ok & is_bcd(load_val[4*i +: 4]);
        end
        if (clr) begin
            w_set = 1'b1;
        end else if (load) begin
            if (w_ld_ok) begin
                w_set     = 1'b1;
                w_set_val = load_val;
            end else begin
                w_err_nxt = 1'b1;
            end
        end else if (tick) begin
            if (w_wrap) begin
                w_set       = 1'b1;
                w_set_val   = w_down ? C_MAX_BCD : '0;
                w_carry_nxt = 1'b1;
            end else begin
                w_step = 1'b1;
            end
        end
    end

    assign w_en[0] = w_step;

    for (genvar i = 0; i < int'(NDIGITS); i++) begin : g_digit
        if (i > 0) begin : g_chain
            assign w_en[i] = w_en[i-1] & w_term[i-1];
        end

        m_bcd_digit #(
            .RESET_DIGIT (C_RST_BCD[4*i +: 4])
        ) u_digit (
            .clk       (clk),
            .rst_n     (rst_n),
            .i_set     (w_set),
            .i_set_val (w_set_val[4*i +: 4]),
            .i_en      (w_en[i]),
            .i_down    (w_down),
            .o_digit   (w_digit[i]),
            .o_term    (w_term[i])
        );

        assign count[4*i +: 4] = w_digit[i];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_carry    <= 1'b0;
            r_load_err <= 1'b0;
        end else begin
            r_carry    <= w_carry_nxt;
            r_load_err <= w_err_nxt;
        end
    end

    assign carry    = r_carry;
    assign load_err = r_load_err;

endmodule

// File: tb/tb_m_gen_bcd_cnt.sv
// Bench for m_gen_bcd_cnt: a mod-60 (reset 59) and a 3-digit mod-100 instance,
// checked cycle by cycle against a binary reference model through a scoreboard queue.
module tb_m_gen_bcd_cnt;

    typedef struct packed {
        logic [11:0] cnt;
        logic        cy;
        logic        le;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        tick = 1'b0;
    logic        clr = 1'b0;
    logic        load = 1'b0;
    logic [7:0]  load_val = '0;
    logic [7:0]  count;
    logic        carry;
    logic        load_err;
`ifdef GEN_BCD_CNT_DOWN_EN
    logic        down = 1'b0;
`endif

    logic        tick3 = 1'b0;
    logic [11:0] count3;
    logic        carry3;
    logic        lerr3;

    exp_t q[$];
    exp_t q3[$];
    int   errors = 0;
    int   checks = 0;
    int   n_carry = 0;
    int   n_carry3 = 0;
    int   m_a = 59;
    int   m_b = 0;
    bit   m_down = 1'b0;

    always #5 clk = ~clk;

    m_gen_bcd_cnt #(
        .NDIGITS     (2),
        .MODULUS     (60),
        .RESET_VALUE (59)
    ) u_dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .tick     (tick),
        .clr      (clr),
        .load     (load),
`ifdef GEN_BCD_CNT_DOWN_EN
        .down     (down),
`endif
        .load_val (load_val),
        .count    (count),
        .carry    (carry),
        .load_err (load_err)
    );

    m_gen_bcd_cnt #(
        .NDIGITS     (3),
        .MODULUS     (100),
        .RESET_VALUE (0)
    ) u_dut3 (
        .clk      (clk),
        .rst_n    (rst_n),
        .tick     (tick3),
        .clr      (1'b0),
        .load     (1'b0),
`ifdef GEN_BCD_CNT_DOWN_EN
        .down     (1'b0),
`endif
        .load_val (12'h000),
        .count    (count3),
        .carry    (carry3),
        .load_err (lerr3)
    );

    function automatic logic [11:0] bin2bcd(input int v);
        return {4'(v / 100 % 10), 4'(v / 10 % 10), 4'(v % 10)};
    endfunction

    function automatic int bcd2bin(input logic [7:0] v);
        return int'(v[7:4]) * 10 + int'(v[3:0]);
    endfunction

    task automatic check(input string tag, input logic [11:0] obs, input logic [11:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp_v);
        end
    endtask

    // One clock of the mod-60 instance: model the request, queue the expectation, compare.
    task automatic cyc(input string tag, input logic t, input logic c, input logic l,
                       input logic [7:0] v);
        exp_t e;
        e = '0;
        tick = t; clr = c; load = l; load_val = v;
        if (c) begin
            m_a = 0;
        end else if (l) begin
            if (v[7:4] <= 4'd9 && v[3:0] <= 4'd9 && bcd2bin(v) < 60) m_a = bcd2bin(v);
            else e.le = 1'b1;
        end else if (t) begin
            if (m_down) begin
                if (m_a == 0) begin m_a = 59; e.cy = 1'b1; end
                else m_a--;
            end else begin
                if (m_a == 59) begin m_a = 0; e.cy = 1'b1; end
                else m_a++;
            end
        end
        e.cnt = bin2bcd(m_a);
        q.push_back(e);
        @(posedge clk);
        #1;
        tick = 1'b0; clr = 1'b0; load = 1'b0;
        e = q.pop_front();
        if (carry) n_carry++;
        check({tag, ".count"}, {4'h0, count}, e.cnt);
        check({tag, ".carry"}, {11'h0, carry}, {11'h0, e.cy});
        check({tag, ".load_err"}, {11'h0, load_err}, {11'h0, e.le});
    endtask

    task automatic cyc3(input string tag, input logic t);
        exp_t e;
        e = '0;
        tick3 = t;
        if (t) begin
            if (m_b == 99) begin m_b = 0; e.cy = 1'b1; end
            else m_b++;
        end
        e.cnt = bin2bcd(m_b);
        q3.push_back(e);
        @(posedge clk);
        #1;
        tick3 = 1'b0;
        e = q3.pop_front();
        if (carry3) n_carry3++;
        check({tag, ".count3"}, count3, e.cnt);
        check({tag, ".carry3"}, {11'h0, carry3}, {11'h0, e.cy});
    endtask

    initial begin
        // Reset state
        #12;
        check("rst.count", {4'h0, count}, 12'h059);
        check("rst.carry", {11'h0, carry}, 12'h000);
        check("rst.load_err", {11'h0, load_err}, 12'h000);
        check("rst.count3", count3, 12'h000);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Wrap straight out of reset, carry only one cycle wide
        cyc("t1.tick", 1'b1, 1'b0, 1'b0, 8'h00);
        cyc("t1.idle", 1'b0, 1'b0, 1'b0, 8'h00);

        // Full revolution with random gaps
        n_carry = 0;
        for (int i = 0; i < 60; i++) begin
            repeat ($urandom_range(0, 3)) cyc("t2.idle", 1'b0, 1'b0, 1'b0, 8'h00);
            cyc("t2.tick", 1'b1, 1'b0, 1'b0, 8'h00);
        end
        check("t2.n_carry", 12'(n_carry), 12'd1);

        // Loads: accepted, out of range, non-BCD digit, load beats tick
        cyc("t3.ld37", 1'b0, 1'b0, 1'b1, 8'h37);
        cyc("t3.ld60", 1'b0, 1'b0, 1'b1, 8'h60);
        cyc("t3.ld4A", 1'b0, 1'b0, 1'b1, 8'h4A);
        cyc("t3.ldA0", 1'b0, 1'b0, 1'b1, 8'hA0);
        cyc("t3.idle", 1'b0, 1'b0, 1'b0, 8'h00);
        cyc("t3.ldtick", 1'b1, 1'b0, 1'b1, 8'h12);
        cyc("t3.tick", 1'b1, 1'b0, 1'b0, 8'h00);
        cyc("t3.ld09", 1'b0, 1'b0, 1'b1, 8'h09);
        cyc("t3.tick09", 1'b1, 1'b0, 1'b0, 8'h00);

        // clr wins over load and tick at the wrap point
        cyc("t4.ld59", 1'b0, 1'b0, 1'b1, 8'h59);
        cyc("t4.all", 1'b1, 1'b1, 1'b1, 8'h12);
        cyc("t4.idle", 1'b0, 1'b0, 1'b0, 8'h00);

        // Three-digit mod-100 instance
        n_carry3 = 0;
        for (int i = 0; i < 100; i++) cyc3("t5.tick", 1'b1);
        cyc3("t5.idle", 1'b0);
        check("t5.n_carry3", 12'(n_carry3), 12'd1);

`ifdef GEN_BCD_CNT_DOWN_EN
        // Down counting with borrow
        cyc("t6.ld00", 1'b0, 1'b0, 1'b1, 8'h00);
        m_down = 1'b1;
        down = 1'b1;
        cyc("t6.dn0", 1'b1, 1'b0, 1'b0, 8'h00);
        cyc("t6.dn1", 1'b1, 1'b0, 1'b0, 8'h00);
        cyc("t6.ld50", 1'b0, 1'b0, 1'b1, 8'h50);
        cyc("t6.dn50", 1'b1, 1'b0, 1'b0, 8'h00);
        m_down = 1'b0;
        down = 1'b0;
`endif

        // Asynchronous reset while a carry pulse is showing
        cyc("t7.ld59", 1'b0, 1'b0, 1'b1, 8'h59);
        cyc("t7.wrap", 1'b1, 1'b0, 1'b0, 8'h00);
        #2;
        rst_n = 1'b0;
        m_a = 59;
        m_b = 0;
        #1;
        check("t7.async.count", {4'h0, count}, 12'h059);
        check("t7.async.carry", {11'h0, carry}, 12'h000);
        #2;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        cyc("t7.after", 1'b0, 1'b0, 1'b0, 8'h00);
        cyc("t7.tick", 1'b1, 1'b0, 1'b0, 8'h00);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
